// File: rtl/ether_pkg.sv
// rtl/ether_pkg.sv - shared RMII framer types, constants and CRC bit step
`timescale 1ns/1ps
package ether_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DEST,
        SRC,
        ETYPE,
        PAYLOAD,
        DROP
    } state_t;

    localparam logic [47:0] BCAST_MAC    = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;
    localparam int          MAC_DIBITS   = 24;
    localparam int          ETYPE_DIBITS = 8;

    // One LSB-first step of the reflected CRC-32 register.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - reflected CRC-32 register advanced one dibit per cycle
`timescale 1ns/1ps
module crc32_dibit
    import ether_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        valid,
    input  logic [1:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC_INIT;
        end else if (valid) begin
            crc_d = crc_bit(crc_bit(crc_q, din[0]), din[1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ethernet_rx.sv
// rtl/ethernet_rx.sv - RMII receive framer: preamble/SFD, header parse, address filter, payload stream, FCS check
`timescale 1ns/1ps
module ethernet_rx
    import ether_pkg::*;
#(
    parameter int N       = 2,
    parameter int MIN_PRE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  rxd,
    input  logic          crsdv,
    input  logic [47:0]   my_mac,
    output logic          axiov,
    output logic [N-1:0]  axiod,
    output logic [47:0]   src_mac,
    output logic [15:0]   etype,
    output logic          frame_done,
    output logic          crc_ok
);

    localparam logic [3:0] MIN_PRE_C = 4'(MIN_PRE);

    state_t        state_q, state_d;
    logic [3:0]    pre_cnt_q, pre_cnt_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic [47:0]   field_q, field_d;
    logic [47:0]   src_mac_q, src_mac_d;
    logic [15:0]   etype_q, etype_d;
    logic          axiov_q, axiov_d;
    logic [N-1:0]  axiod_q, axiod_d;
    logic          frame_done_q, frame_done_d;
    logic          crc_ok_q, crc_ok_d;
    logic          armed_q, armed_d;
    logic          pay_seen_q, pay_seen_d;

    logic          crc_clear, crc_valid, hdr;
    logic [7:0]    byte_done;
    logic [47:0]   field_next;
    logic [31:0]   crc;

    crc32_dibit u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (crc_clear),
        .valid (crc_valid),
        .din   (rxd),
        .crc   (crc)
    );

    // Dibits fill a byte LSB-first; completed bytes shift in MSB-byte-first.
    assign byte_done  = {rxd, byte_q[7:2]};
    assign field_next = {field_q[39:0], byte_done};
    assign hdr        = crsdv && (state_q == DEST || state_q == SRC || state_q == ETYPE);

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        field_d      = field_q;
        src_mac_d    = src_mac_q;
        etype_d      = etype_q;
        pay_seen_d   = pay_seen_q;
        axiov_d      = 1'b0;
        axiod_d      = '0;
        frame_done_d = 1'b0;
        crc_ok_d     = 1'b0;
        crc_clear    = 1'b0;
        crc_valid    = 1'b0;

        if (hdr) begin
            byte_d    = byte_done;
            crc_valid = 1'b1;
            cnt_d     = cnt_q + 5'd1;
            if (cnt_q[1:0] == 2'd3) field_d = field_next;
        end

        case (state_q)
            IDLE: begin
                if (crsdv && rxd == 2'b01 && armed_q) begin
                    state_d   = PRE;
                    pre_cnt_d = 4'd1;
                end
            end
            PRE: begin
                if (!crsdv) begin
                    state_d = IDLE;
                end else if (rxd == 2'b01) begin
                    pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
                end else if (rxd == 2'b11 && pre_cnt_q >= MIN_PRE_C) begin
                    state_d   = DEST;
                    crc_clear = 1'b1;
                    cnt_d     = '0;
                end else begin
                    state_d = DROP;
                end
            end
            DEST: begin
                if (!crsdv) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'(MAC_DIBITS - 1)) begin
                    cnt_d   = '0;
                    state_d = (field_next == my_mac || field_next == BCAST_MAC) ? SRC : DROP;
                end
            end
            SRC: begin
                if (!crsdv) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'(MAC_DIBITS - 1)) begin
                    cnt_d     = '0;
                    src_mac_d = field_next;
                    state_d   = ETYPE;
                end
            end
            ETYPE: begin
                if (!crsdv) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'(ETYPE_DIBITS - 1)) begin
                    cnt_d      = '0;
                    etype_d    = field_next[15:0];
                    pay_seen_d = 1'b0;
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (crsdv) begin
                    axiov_d    = 1'b1;
                    axiod_d    = rxd;
                    crc_valid  = 1'b1;
                    pay_seen_d = 1'b1;
                end else begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    crc_ok_d     = pay_seen_q && (crc == CRC_RESIDUE);
                end
            end
            default: begin
                if (!crsdv) state_d = IDLE;
            end
        endcase

        // A preamble is only honoured after carrier has been seen low, so a
        // reset in mid-frame cannot lock onto stray 01 dibits in the payload.
        armed_d = !crsdv || (armed_q && state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            byte_q       <= '0;
            field_q      <= '0;
            src_mac_q    <= '0;
            etype_q      <= '0;
            axiov_q      <= 1'b0;
            axiod_q      <= '0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            armed_q      <= 1'b0;
            pay_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            field_q      <= field_d;
            src_mac_q    <= src_mac_d;
            etype_q      <= etype_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            frame_done_q <= frame_done_d;
            crc_ok_q     <= crc_ok_d;
            armed_q      <= armed_d;
            pay_seen_q   <= pay_seen_d;
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign src_mac    = src_mac_q;
    assign etype      = etype_q;
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;

endmodule

// File: tb/tb_ethernet_rx.sv
// tb/tb_ethernet_rx.sv - directed self-checking bench for ethernet_rx
`timescale 1ns/1ps
module tb_ethernet_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crsdv = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic [47:0] my_mac = 48'h1234_5678_90AB;
    logic        axiov;
    logic [1:0]  axiod;
    logic [47:0] src_mac;
    logic [15:0] etype;
    logic        frame_done;
    logic        crc_ok;

    ethernet_rx #(.N(2), .MIN_PRE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .crsdv      (crsdv),
        .my_mac     (my_mac),
        .axiov      (axiov),
        .axiod      (axiod),
        .src_mac    (src_mac),
        .etype      (etype),
        .frame_done (frame_done),
        .crc_ok     (crc_ok)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] frm [0:127];
    int         flen = 0;
    logic [1:0] exp_dib [0:511];

    int run_idx = 0, last_run = 0, dib_err = 0, tot_v = 0, done_cnt = 0, ok_cnt = 0;
    int b_done, b_ok, b_tot;

    always @(negedge clk) begin
        if (axiov) begin
            if (axiod !== exp_dib[run_idx]) dib_err++;
            run_idx++;
            tot_v++;
        end else if (run_idx != 0) begin
            last_run = run_idx;
            run_idx  = 0;
        end
        if (frame_done) begin
            done_cnt++;
            if (crc_ok) ok_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [1:0] get_dib(input int i);
        logic [7:0] b;
        b = frm[i / 4];
        return b[2 * (i % 4) +: 2];
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input int npay, input int flip_byte);
        logic [31:0] c;
        for (int j = 0; j < 6; j++) begin
            frm[j]     = dst[47 - 8 * j -: 8];
            frm[6 + j] = src[47 - 8 * j -: 8];
        end
        frm[12] = et[15:8];
        frm[13] = et[7:0];
        for (int j = 0; j < npay; j++) frm[14 + j] = 8'(j);
        c = 32'hFFFF_FFFF;
        for (int j = 0; j < 14 + npay; j++) c = crc_byte(c, frm[j]);
        c = ~c;
        for (int j = 0; j < 4; j++) frm[14 + npay + j] = c[8 * j +: 8];
        flen = 18 + npay;
        if (flip_byte >= 0) frm[14 + flip_byte] = frm[14 + flip_byte] ^ 8'h08;
        for (int i = 0; i < (npay + 4) * 4; i++) exp_dib[i] = get_dib(56 + i);
    endtask

    task automatic step(input logic c, input logic [1:0] d);
        crsdv = c;
        rxd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int npre, input int nlim, input int gap);
        int n;
        for (int i = 0; i < npre; i++) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        n = (nlim < 0) ? flen * 4 : nlim;
        for (int i = 0; i < n; i++) step(1'b1, get_dib(i));
        for (int i = 0; i < gap; i++) step(1'b0, 2'b00);
    endtask

    task automatic snap();
        b_done = done_cnt;
        b_ok   = ok_cnt;
        b_tot  = tot_v;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step(1'b0, 2'b00);
        chk("rst_axiov", 64'(axiov), 64'd0);
        chk("rst_axiod", 64'(axiod), 64'd0);
        chk("rst_src_mac", 64'(src_mac), 64'd0);
        chk("rst_etype", 64'(etype), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_crc_ok", 64'(crc_ok), 64'd0);
        rst = 1'b0;
        repeat (2) step(1'b0, 2'b00);

        // good broadcast frame
        build(48'hFFFF_FFFF_FFFF, 48'h1234_5678_90AB, 16'hF0F0, 46, -1);
        snap();
        send(31, -1, 4);
        chk("bc_done", 64'(done_cnt - b_done), 64'd1);
        chk("bc_crc_ok", 64'(ok_cnt - b_ok), 64'd1);
        chk("bc_len", 64'(last_run), 64'd200);
        chk("bc_data", 64'(dib_err), 64'd0);
        chk("bc_src_mac", 64'(src_mac), 64'h1234_5678_90AB);
        chk("bc_etype", 64'(etype), 64'hF0F0);

        // one payload bit flipped
        build(48'hFFFF_FFFF_FFFF, 48'h1234_5678_90AB, 16'hF0F0, 46, 5);
        snap();
        send(31, -1, 4);
        chk("flip_done", 64'(done_cnt - b_done), 64'd1);
        chk("flip_crc_ok", 64'(ok_cnt - b_ok), 64'd0);
        chk("flip_len", 64'(last_run), 64'd200);
        chk("flip_data", 64'(dib_err), 64'd0);

        // unicast hit
        build(48'h1234_5678_90AB, 48'hA1B2_C3D4_E5F6, 16'h0800, 46, -1);
        snap();
        send(31, -1, 4);
        chk("uc_done", 64'(done_cnt - b_done), 64'd1);
        chk("uc_crc_ok", 64'(ok_cnt - b_ok), 64'd1);
        chk("uc_src_mac", 64'(src_mac), 64'hA1B2_C3D4_E5F6);
        chk("uc_etype", 64'(etype), 64'h0800);

        // unicast miss
        build(48'h0200_0000_0001, 48'h1111_1111_1111, 16'h86DD, 46, -1);
        snap();
        send(31, -1, 4);
        chk("miss_axiov", 64'(tot_v - b_tot), 64'd0);
        chk("miss_done", 64'(done_cnt - b_done), 64'd0);
        chk("miss_src_mac", 64'(src_mac), 64'hA1B2_C3D4_E5F6);
        chk("miss_etype", 64'(etype), 64'h0800);

        // short preamble dropped, then legal frame after 1-cycle gap
        build(48'hFFFF_FFFF_FFFF, 48'h1234_5678_90AB, 16'hF0F0, 46, -1);
        snap();
        send(3, -1, 1);
        send(31, -1, 4);
        chk("shpre_done", 64'(done_cnt - b_done), 64'd1);
        chk("shpre_crc_ok", 64'(ok_cnt - b_ok), 64'd1);
        chk("shpre_axiov", 64'(tot_v - b_tot), 64'd200);
        chk("shpre_src_mac", 64'(src_mac), 64'h1234_5678_90AB);

        // zero payload: carrier drops right after ethertype
        build(48'hFFFF_FFFF_FFFF, 48'hCAFE_BABE_0001, 16'h0806, 46, -1);
        snap();
        send(31, 56, 4);
        chk("zp_done", 64'(done_cnt - b_done), 64'd1);
        chk("zp_crc_ok", 64'(ok_cnt - b_ok), 64'd0);
        chk("zp_axiov", 64'(tot_v - b_tot), 64'd0);
        chk("zp_etype", 64'(etype), 64'h0806);

        // runt after 10 dest dibits
        snap();
        send(31, 10, 4);
        chk("runt_done", 64'(done_cnt - b_done), 64'd0);
        chk("runt_axiov", 64'(tot_v - b_tot), 64'd0);
        chk("runt_src_mac", 64'(src_mac), 64'hCAFE_BABE_0001);

        // reset in the middle of the payload
        build(48'hFFFF_FFFF_FFFF, 48'h1234_5678_90AB, 16'hF0F0, 46, -1);
        snap();
        send(31, 96, 0);
        chk("mid_axiov_pre", 64'(axiov), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_axiov_rst", 64'(axiov), 64'd0);
        chk("mid_src_mac_rst", 64'(src_mac), 64'd0);
        chk("mid_etype_rst", 64'(etype), 64'd0);
        for (int i = 96; i < flen * 4; i++) begin
            step(1'b1, get_dib(i));
            rst = 1'b0;
        end
        repeat (4) step(1'b0, 2'b00);
        chk("mid_done", 64'(done_cnt - b_done), 64'd0);
        snap();
        send(31, -1, 4);
        chk("post_rst_done", 64'(done_cnt - b_done), 64'd1);
        chk("post_rst_crc_ok", 64'(ok_cnt - b_ok), 64'd1);
        chk("post_rst_len", 64'(last_run), 64'd200);
        chk("post_rst_data", 64'(dib_err), 64'd0);

        // back-to-back frames with a 1-cycle carrier gap
        snap();
        send(31, -1, 1);
        send(31, -1, 4);
        chk("b2b_done", 64'(done_cnt - b_done), 64'd2);
        chk("b2b_crc_ok", 64'(ok_cnt - b_ok), 64'd2);
        chk("b2b_axiov", 64'(tot_v - b_tot), 64'd400);
        chk("b2b_data", 64'(dib_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
